// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizes for the truth-table sweeper.
package truth_table_sweeper_pkg;
  localparam int ROWS     = 8;
  localparam int ROW_W    = 3;
  localparam int CNT_W    = 4;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;
endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Per-row settle countdown: load SETTLE, count down while enabled, flag zero.
module truth_table_sweeper_settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);
  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= SETTLE_W'(SETTLE);
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight {a,b,c} rows into an external function unit, samples s after
// a settle delay, and scores the measured table against a latched golden table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ROWS-1:0]  expected,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             s,
  output logic [ROW_W-1:0] row,
  output logic             busy,
  output logic             done,
  output logic [ROWS-1:0]  table_out,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [ROW_W-1:0] first_bad
);
  state_e           state, state_nxt;
  logic [ROWS-1:0]  exp_q;
  logic             accept, sample, last_row, mis, tmr_zero, tmr_load;
  logic [CNT_W-1:0] cnt_nxt;

  assign accept   = (state == IDLE) && start;
  assign sample   = (state == RUN) && tmr_zero;
  assign last_row = (row == ROW_W'(ROWS-1));
  assign mis      = (s != exp_q[row]);
  assign cnt_nxt  = mismatch_cnt + CNT_W'(mis);
  assign tmr_load = accept || (sample && !last_row);

  // Function inputs are the registered row index itself.
  assign {a, b, c} = row;

  truth_table_sweeper_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .en    (state == RUN),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (sample && last_row) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q        <= '0;
      row          <= '0;
      table_out    <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
    end else if (accept) begin
      exp_q        <= expected;
      row          <= '0;
      table_out    <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
    end else if (sample) begin
      table_out[row] <= s;
      if (mis) begin
        mismatch_cnt <= cnt_nxt;
        if (mismatch_cnt == '0) first_bad <= row;
      end
      // pass is resolved on the final sample so it is valid alongside done.
      if (last_row) pass <= (cnt_nxt == '0);
      else          row  <= row + 1'b1;
    end else if (state == FINISH) begin
      row <= '0;
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: sweeps s = a | (b & ~c) (table 8'hF4) with SETTLE=1 and SETTLE=0.
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       reset1, start1, reset0, start0;
  logic [7:0] expected1, expected0;
  logic       a1, b1, c1, s1, busy1, done1, pass1;
  logic       a0, b0, c0, s0, busy0, done0, pass0;
  logic [2:0] row1, first_bad1, row0, first_bad0;
  logic [7:0] table1, table0;
  logic [3:0] cnt1, cnt0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign s1 = a1 | (b1 & ~c1);
  assign s0 = a0 | (b0 & ~c0);

  truth_table_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset1), .start(start1), .expected(expected1),
    .a(a1), .b(b1), .c(c1), .s(s1), .row(row1), .busy(busy1), .done(done1),
    .table_out(table1), .pass(pass1), .mismatch_cnt(cnt1), .first_bad(first_bad1)
  );

  truth_table_sweeper #(.SETTLE(0)) u_dut0 (
    .clk(clk), .reset(reset0), .start(start0), .expected(expected0),
    .a(a0), .b(b0), .c(c0), .s(s0), .row(row0), .busy(busy0), .done(done0),
    .table_out(table0), .pass(pass0), .mismatch_cnt(cnt0), .first_bad(first_bad0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with u_dut1 idle; returns #1 after the done edge.
  task automatic sweep1(input logic [7:0] tbl, output int done_edge, output int busy_cyc);
    expected1 = tbl;
    start1    = 1'b1;
    @(posedge clk); #1;
    start1    = 1'b0;
    done_edge = -1;
    busy_cyc  = busy1 ? 1 : 0;
    for (int k = 1; k <= 40 && done_edge < 0; k++) begin
      @(posedge clk); #1;
      if (done1) done_edge = k;
      else if (busy1) busy_cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] tbl, input logic p,
                              input logic [3:0] n, input logic [2:0] fb);
    chk({tag, "_table"}, 32'(table1), 32'(tbl));
    chk({tag, "_pass"}, 32'(pass1), 32'(p));
    chk({tag, "_cnt"}, 32'(cnt1), 32'(n));
    chk({tag, "_first_bad"}, 32'(first_bad1), 32'(fb));
  endtask

  initial begin
    int de, bc, found;
    logic [23:0] abc_trace;

    reset1 = 1'b1; reset0 = 1'b1;
    start1 = 1'b0; start0 = 1'b0;
    expected1 = 8'h00; expected0 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {busy1, done1, pass1, row1, a1, b1, c1, table1, cnt1, first_bad1}, 32'h0);
    reset1 = 1'b0; reset0 = 1'b0;
    @(posedge clk); #1;

    sweep1(8'hF4, de, bc);
    chk("f4_done_edge", 32'(de), 32'd16);
    chk("f4_busy_cycles", 32'(bc), 32'd16);
    chk("f4_busy_at_done", 32'(busy1), 32'd0);
    check_result("f4", 8'hF4, 1'b1, 4'd0, 3'd0);
    @(posedge clk); #1;
    chk("done_pulse_width", 32'(done1), 32'd0);
    chk("results_hold_idle", {table1, 7'd0, pass1}, {8'hF4, 8'h01});

    sweep1(8'hF5, de, bc);
    check_result("f5", 8'hF4, 1'b0, 4'd1, 3'd0);
    @(posedge clk); #1;
    sweep1(8'hB4, de, bc);
    check_result("b4", 8'hF4, 1'b0, 4'd1, 3'd6);
    @(posedge clk); #1;
    sweep1(8'h0B, de, bc);
    check_result("0b", 8'hF4, 1'b0, 4'd8, 3'd0);
    @(posedge clk); #1;

    // SETTLE=0: one row per cycle.
    expected0 = 8'hF4;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abc_trace = '0;
    abc_trace[2:0] = {a0, b0, c0};
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      abc_trace[3*k +: 3] = {a0, b0, c0};
    end
    chk("s0_abc_steps", 32'(abc_trace), 32'(24'o76543210));
    chk("s0_no_early_done", 32'(done0), 32'd0);
    @(posedge clk); #1;
    chk("s0_done_edge8", 32'(done0), 32'd1);
    chk("s0_table", 32'(table0), 32'hF4);
    chk("s0_pass", 32'(pass0), 32'd1);
    @(posedge clk); #1;
    chk("s0_abc_back_to_0", 32'({a0, b0, c0, row0}), 32'd0);

    // start held high; expected changed mid-sweep must not matter.
    expected1 = 8'hF4;
    start1 = 1'b1;
    @(posedge clk); #1;
    de = -1;
    for (int k = 1; k <= 40 && de < 0; k++) begin
      @(posedge clk); #1;
      if (k == 5) expected1 = 8'h00;
      if (done1) de = k;
    end
    chk("held_done_edge", 32'(de), 32'd16);
    check_result("held", 8'hF4, 1'b1, 4'd0, 3'd0);
    @(posedge clk); #1;
    chk("held_idle_not_busy", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    chk("held_reaccept", 32'(busy1), 32'd1);
    start1 = 1'b0;

    // Asynchronous reset once row 4 is being driven.
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (row1 == 3'd4) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("reached_row4", 32'(found), 32'd1);
    #2 reset1 = 1'b1;
    #1;
    chk("async_reset_outs", {busy1, done1, pass1, row1, a1, b1, c1, table1, cnt1, first_bad1}, 32'h0);
    @(posedge clk); #1;
    reset1 = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(busy1), 32'd0);
    sweep1(8'hF4, de, bc);
    chk("post_reset_done_edge", 32'(de), 32'd16);
    check_result("post_reset", 8'hF4, 1'b1, 4'd0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
